// File: rtl/elev_pkg.sv
// Shared elevator constants: floor count, direction and car-state codes.
// Used by req_scheduler and floor_mask.
package elev_pkg;

  localparam int N_FLOORS = 4;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_e;

  localparam logic [2:0] ST_STOP  = 3'b000;
  localparam logic [2:0] ST_PAUSE = 3'b001;
  localparam logic [2:0] ST_MOVE  = 3'b010;

  // Top floor has no up call, bottom floor no down call.
  localparam logic [N_FLOORS-1:0] UP_VALID = 4'b0111;
  localparam logic [N_FLOORS-1:0] DN_VALID = 4'b1110;

  function automatic logic onehot4(
    input logic [N_FLOORS-1:0] v
  );
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/floor_mask.sv
// Splits a request vector into floors above and below a one-hot position.
// A zero position yields empty masks.
module floor_mask
  import elev_pkg::*;
(
  input  logic [N_FLOORS-1:0] position,
  input  logic [N_FLOORS-1:0] req,
  output logic [N_FLOORS-1:0] above,
  output logic [N_FLOORS-1:0] below
);

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      for (int j = 0; j < N_FLOORS; j++) begin
        if (position[j]) begin
          if (i > j) above[i] = req[i];
          if (i < j) below[i] = req[i];
        end
      end
    end
  end

endmodule

// File: rtl/req_scheduler.sv
// Elevator request latching and direction scheduling.
// Optional HALL_DIR_FILTER_EN: hall calls filtered by travel direction.
module req_scheduler
  import elev_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                switch,
  input  logic [N_FLOORS-1:0] car_btn,
  input  logic [N_FLOORS-1:0] up_btn,
  input  logic [N_FLOORS-1:0] dn_btn,
  input  logic [N_FLOORS-1:0] position,
  input  logic [2:0]          state,
  input  logic                opendoor,
  output logic [N_FLOORS-1:0] eff_req,
  output logic [1:0]          ud_mode,
  output logic                pending
);

  logic [N_FLOORS-1:0] car_req;
  logic [N_FLOORS-1:0] up_req;
  logic [N_FLOORS-1:0] dn_req;
  logic [N_FLOORS-1:0] all_req;
  logic [N_FLOORS-1:0] above;
  logic [N_FLOORS-1:0] below;
  logic [N_FLOORS-1:0] clr_car;
  logic [N_FLOORS-1:0] clr_up;
  logic [N_FLOORS-1:0] clr_dn;
  logic [N_FLOORS-1:0] nxt_eff;
  logic                pos_ok;
  logic                serve;
  dir_e                dir;
  dir_e                nxt_dir;

  assign all_req = car_req | up_req | dn_req;
  assign pos_ok  = onehot4(position);
  assign serve   = pos_ok && (state == ST_PAUSE) && opendoor;
  assign clr_car = serve ? position : '0;

  floor_mask u_mask (
    .position (position),
    .req      (all_req),
    .above    (above),
    .below    (below)
  );

  // Direction only changes while the car is not travelling.
  always_comb begin
    nxt_dir = dir;
    if (!pos_ok) begin
      nxt_dir = DIR_IDLE;
    end else if (state != ST_MOVE) begin
      case (dir)
        DIR_IDLE: begin
          if (|above)      nxt_dir = DIR_UP;
          else if (|below) nxt_dir = DIR_DN;
        end
        DIR_UP: begin
          if (!(|above)) nxt_dir = (|below) ? DIR_DN : DIR_IDLE;
        end
        DIR_DN: begin
          if (!(|below)) nxt_dir = (|above) ? DIR_UP : DIR_IDLE;
        end
        default: nxt_dir = DIR_IDLE;
      endcase
    end
  end

`ifdef HALL_DIR_FILTER_EN
  logic [N_FLOORS-1:0] up_turn;
  logic [N_FLOORS-1:0] dn_turn;

  // Opposite calls count only at the extreme requested floor.
  always_comb begin
    up_turn = '0;
    dn_turn = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      dn_turn[i] = dn_req[i] && ((all_req >> (i + 1)) == '0);
      up_turn[i] = up_req[i] &&
                   ((all_req & ((4'd1 << i) - 4'd1)) == '0);
    end
  end

  always_comb begin
    case (nxt_dir)
      DIR_UP:  nxt_eff = car_req | up_req | dn_turn;
      DIR_DN:  nxt_eff = car_req | dn_req | up_turn;
      default: nxt_eff = all_req;
    endcase
  end

  assign clr_up = (serve && (dir != DIR_DN || |(up_turn & position)))
                ? position : '0;
  assign clr_dn = (serve && (dir != DIR_UP || |(dn_turn & position)))
                ? position : '0;
`else
  assign nxt_eff = all_req;
  assign clr_up  = clr_car;
  assign clr_dn  = clr_car;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_req <= '0;
      up_req  <= '0;
      dn_req  <= '0;
      dir     <= DIR_IDLE;
      eff_req <= '0;
      ud_mode <= DIR_IDLE;
      pending <= 1'b0;
    end else if (!switch) begin
      car_req <= '0;
      up_req  <= '0;
      dn_req  <= '0;
      dir     <= DIR_IDLE;
      eff_req <= '0;
      ud_mode <= DIR_IDLE;
      pending <= 1'b0;
    end else begin
      car_req <= (car_req | car_btn) & ~clr_car;
      up_req  <= (up_req | (up_btn & UP_VALID)) & ~clr_up;
      dn_req  <= (dn_req | (dn_btn & DN_VALID)) & ~clr_dn;
      dir     <= nxt_dir;
      eff_req <= pos_ok ? nxt_eff : '0;
      ud_mode <= nxt_dir;
      pending <= |all_req;
    end
  end

endmodule

// File: tb/tb_req_scheduler.sv
// Self-checking bench for req_scheduler: directed steps plus random
// traffic against a floor-index reference model.
module tb_req_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       switch;
  logic [3:0] car_btn;
  logic [3:0] up_btn;
  logic [3:0] dn_btn;
  logic [3:0] position;
  logic [2:0] state;
  logic       opendoor;
  logic [3:0] eff_req;
  logic [1:0] ud_mode;
  logic       pending;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_car, m_up, m_dn;
  int         m_dir;
  logic [3:0] e_eff;
  logic [1:0] e_ud;
  logic       e_pend;

  req_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .switch   (switch),
    .car_btn  (car_btn),
    .up_btn   (up_btn),
    .dn_btn   (dn_btn),
    .position (position),
    .state    (state),
    .opendoor (opendoor),
    .eff_req  (eff_req),
    .ud_mode  (ud_mode),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_car = '0; m_up = '0; m_dn = '0; m_dir = 0;
    e_eff = '0; e_ud = '0; e_pend = 1'b0;
  endtask

  // Reference: floor index, lowest/highest request, simple flags.
  task automatic model_edge();
    int p, hi, lo, nd;
    logic ab, be, r;
    logic [3:0] e, cc, cu, cd;
    if (!switch) begin
      model_reset();
      return;
    end
    p = -1;
    if ($countones(position) == 1)
      for (int f = 0; f < 4; f++) if (position[f]) p = f;
    hi = -1; lo = 4; ab = 0; be = 0;
    for (int f = 0; f < 4; f++) begin
      r = m_car[f] | m_up[f] | m_dn[f];
      if (r) begin
        if (f > hi) hi = f;
        if (f < lo) lo = f;
        if (p >= 0 && f > p) ab = 1;
        if (p >= 0 && f < p) be = 1;
      end
    end
    nd = m_dir;
    if (p < 0) nd = 0;
    else if (state != 3'b010) begin
      if (m_dir == 2) nd = be ? 2 : (ab ? 1 : 0);
      else            nd = ab ? 1 : (be ? 2 : 0);
    end
    e = '0;
    if (p >= 0)
      for (int f = 0; f < 4; f++) begin
`ifdef HALL_DIR_FILTER_EN
        if (nd == 1)
          e[f] = m_car[f] | m_up[f] | (m_dn[f] && f == hi);
        else if (nd == 2)
          e[f] = m_car[f] | m_dn[f] | (m_up[f] && f == lo);
        else
          e[f] = m_car[f] | m_up[f] | m_dn[f];
`else
        e[f] = m_car[f] | m_up[f] | m_dn[f];
`endif
      end
    e_eff  = e;
    e_ud   = 2'(nd);
    e_pend = (hi >= 0);
    cc = '0; cu = '0; cd = '0;
    if (p >= 0 && state == 3'b001 && opendoor) begin
      cc[p] = 1'b1;
`ifdef HALL_DIR_FILTER_EN
      if (m_dir != 2 || (m_up[p] && p == lo)) cu[p] = 1'b1;
      if (m_dir != 1 || (m_dn[p] && p == hi)) cd[p] = 1'b1;
`else
      cu[p] = 1'b1;
      cd[p] = 1'b1;
`endif
    end
    m_car = (m_car | car_btn) & ~cc;
    m_up  = (m_up | (up_btn & 4'b0111)) & ~cu;
    m_dn  = (m_dn | (dn_btn & 4'b1110)) & ~cd;
    m_dir = nd;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".eff"}, eff_req, e_eff);
    chk({tag, ".ud"}, {2'b00, ud_mode}, {2'b00, e_ud});
    chk({tag, ".pend"}, {3'b000, pending}, {3'b000, e_pend});
  endtask

  task automatic idle_inputs();
    car_btn = '0; up_btn = '0; dn_btn = '0; opendoor = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; switch = 1'b0; idle_inputs();
    position = 4'b0001; state = 3'b000;
    model_reset();
    #2;
    chk("rst.eff", eff_req, 4'b0000);
    chk("rst.ud", {2'b00, ud_mode}, 4'b0000);
    chk("rst.pend", {3'b000, pending}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Car call above from floor 1
    switch = 1'b1; position = 4'b0001; state = 3'b001;
    car_btn = 4'b0100;
    step("r25a");
    car_btn = '0;
    step("r25b");
    chk("r25.eff", eff_req, 4'b0100);
    chk("r25.ud", {2'b00, ud_mode}, 4'b0001);
    chk("r25.pend", {3'b000, pending}, 4'b0001);

    // Serve the call at floor 3
    position = 4'b0100; state = 3'b001; opendoor = 1'b1;
    step("r26a");
    opendoor = 1'b0;
    step("r26b");
    chk("r26.eff", eff_req, 4'b0000);
    chk("r26.ud", {2'b00, ud_mode}, 4'b0000);
    chk("r26.pend", {3'b000, pending}, 4'b0000);

    // Direction held while moving
    position = 4'b0010; car_btn = 4'b1000;
    step("r27a");
    car_btn = '0;
    step("r27b");
    chk("r27.up", {2'b00, ud_mode}, 4'b0001);
    state = 3'b010; up_btn = 4'b0001;
    step("r27c");
    up_btn = '0; position = 4'b1000;
    step("r27d");
    chk("r27.hold", {2'b00, ud_mode}, 4'b0001);
    state = 3'b001; opendoor = 1'b1;
    step("r27e");
    opendoor = 1'b0;
    chk("r27.turn", {2'b00, ud_mode}, 4'b0010);

    // Invalid position
    switch = 1'b0;
    step("off");
    switch = 1'b1; position = 4'b0000; car_btn = 4'b0010;
    step("r30a");
    car_btn = '0;
    step("r30b");
    chk("r30.eff", eff_req, 4'b0000);
    chk("r30.ud", {2'b00, ud_mode}, 4'b0000);
    chk("r30.pend", {3'b000, pending}, 4'b0001);

    // Asynchronous reset mid-cycle
    position = 4'b0001; car_btn = 4'b1010;
    step("r29a");
    car_btn = '0;
    step("r29b");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("r29.eff", eff_req, 4'b0000);
    chk("r29.ud", {2'b00, ud_mode}, 4'b0000);
    chk("r29.pend", {3'b000, pending}, 4'b0000);
    rst_n = 1'b1;
    switch = 1'b0; car_btn = 4'b1111; up_btn = 4'b1111;
    dn_btn = 4'b1111;
    for (int i = 0; i < 3; i++) step("swoff");
    chk("swoff.pend", {3'b000, pending}, 4'b0000);
    idle_inputs();

`ifdef HALL_DIR_FILTER_EN
    switch = 1'b1; position = 4'b0001; state = 3'b001;
    car_btn = 4'b1000; dn_btn = 4'b0100;
    step("r28a");
    idle_inputs();
    step("r28b");
    chk("r28.eff1", eff_req, 4'b1000);
    chk("r28.ud1", {2'b00, ud_mode}, 4'b0001);
    position = 4'b1000; opendoor = 1'b1;
    step("r28c");
    opendoor = 1'b0;
    step("r28d");
    chk("r28.eff2", eff_req, 4'b0100);
    chk("r28.ud2", {2'b00, ud_mode}, 4'b0010);
    switch = 1'b0;
    step("r28off");
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      switch  = ($urandom_range(0, 24) != 0);
      car_btn = 4'($urandom & $urandom & $urandom);
      up_btn  = 4'($urandom & $urandom & $urandom);
      dn_btn  = 4'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 11);
      if (r < 10)       position = 4'b0001 << (r % 4);
      else if (r == 10) position = 4'b0000;
      else              position = 4'($urandom);
      state    = 3'($urandom_range(0, 2));
      opendoor = ($urandom_range(0, 1) == 1);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
